aes_inv_ark_stage: RTL and testbench

Registered AddRoundKey stage of the AES-128 inverse-cipher datapath. It sits directly upstream of the combinational inverse MixColumns block:
- It holds the 11 round keys in a local store.
- It XORs each incoming 128-bit state with the key selected by its round index.
- It presents the result through a 2-entry valid/ready output buffer.
- It tags each result with whether the downstream InvMixColumns must be applied (rounds 1..NR-1) or bypassed (round 0 and round NR).

---
 rtl/aes_inv_pkg.sv | 28 ++
 rtl/aes_skid_fifo2.sv | 70 +++++++
 rtl/aes_inv_ark_stage.sv | 94 +++++++++
 tb/tb_aes_inv_ark_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_inv_pkg.sv
// Shared types and constants for the AES-128 inverse-cipher datapath.
//   NR / NK_ENTRIES : round count and round-key store depth (NR+1)
//   state_t, round_t: 128-bit state word and 4-bit round index
//   ark_entry_t     : one AddRoundKey result as held in the output buffer
//   is_mix_round()  : 1 when InvMixColumns applies to that round (1..NR-1)
package aes_inv_pkg;

   localparam int NR         = 10;
   localparam int NK_ENTRIES = NR + 1;

   typedef logic [127:0] state_t;
   typedef logic [3:0]   round_t;

   localparam round_t NR_R = round_t'(NR);

   typedef struct packed {
      state_t state;
      round_t round;
      logic   mix;
      logic   keyerr;
   } ark_entry_t;

   // Round 0 and the final round NR skip InvMixColumns.
   function automatic logic is_mix_round(input round_t r);
      return (r >= 4'd1) && (r <= (NR_R - 4'd1));
   endfunction

endpackage

// File: rtl/aes_skid_fifo2.sv
// Two-entry valid/ready buffer, width-parameterised.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid/in_ready    : upstream handshake, in_data accepted on valid && ready
//   out_valid/out_ready  : downstream handshake, head popped on valid && ready
//   in_data / out_data   : W-bit payload; out_data is the head entry
//
// Handshake: a transfer happens at a rising edge where valid && ready are both
// high. Producers hold valid and data stable until that edge. in_ready comes
// from a register (plus the reset gate) and never looks at out_ready, so the
// buffer cuts the ready path. out_data is stable while out_valid && !out_ready.
module aes_skid_fifo2 #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic [1:0]   count_q;
   logic [1:0]   count_n;
   logic         rdy_q;
   logic [W-1:0] head_q;
   logic [W-1:0] tail_q;
   logic         push;
   logic         pop;

   // rdy_q is the registered copy of (count < 2); gating with rst_n holds
   // in_ready low for the whole reset period, including before the first edge.
   assign in_ready  = rdy_q & rst_n;
   assign out_valid = (count_q != 2'd0);
   assign out_data  = head_q;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_n = count_q;
      if (push && !pop) begin
         count_n = count_q + 2'd1;
      end else if (pop && !push) begin
         count_n = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         rdy_q   <= 1'b0;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         count_q <= count_n;
         rdy_q   <= (count_n != 2'd2);
         // The new entry lands in head when the head slot is (or becomes)
         // free this edge; otherwise it queues behind the current head.
         if (push && ((count_q == 2'd0) || pop)) begin
            head_q <= in_data;
         end else if (push) begin
            tail_q <= in_data;
         end else if (pop && (count_q == 2'd2)) begin
            head_q <= tail_q;
         end
      end
   end

endmodule

// File: rtl/aes_inv_ark_stage.sv
// Registered AddRoundKey stage of the AES-128 inverse cipher.
//   clk, rst_n                    : clock, synchronous active-low reset
//   key_we, key_idx, key_data     : round-key store write port (idx > NR ignored)
//   in_valid, in_ready, in_state,
//   in_round                      : incoming state and its round index
//   out_valid, out_ready          : output buffer handshake
//   out_state                     : in_state XOR selected round key
//   out_round                     : round index carried through
//   out_mix                       : route through InvMixColumns (rounds 1..NR-1)
//   out_keyerr                    : key never loaded or round > NR; key taken as 0
module aes_inv_ark_stage
   import aes_inv_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_we,
   input  logic [3:0]   key_idx,
   input  logic [127:0] key_data,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic [3:0]   in_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic [3:0]   out_round,
   output logic         out_mix,
   output logic         out_keyerr
);

   state_t                  key_q [NK_ENTRIES];
   logic [NK_ENTRIES-1:0]   loaded_q;
   logic                    key_wr;
   logic                    rd_ok;
   state_t                  rd_key;
   ark_entry_t              in_entry;
   ark_entry_t              out_entry;

   assign key_wr = rst_n && key_we && (key_idx <= NR_R);

   // Key contents carry no reset; loaded_q alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (key_wr) begin
         key_q[key_idx] <= key_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         loaded_q <= '0;
      end else if (key_wr) begin
         loaded_q[key_idx] <= 1'b1;
      end
   end

   // The store is read before this edge's write lands, so a same-cycle write
   // to the selected index is not seen until the next accept.
   always_comb begin
      rd_ok  = 1'b0;
      rd_key = '0;
      if (in_round <= NR_R) begin
         rd_ok = loaded_q[in_round];
         if (rd_ok) begin
            rd_key = key_q[in_round];
         end
      end
   end

   always_comb begin
      in_entry.state  = in_state ^ rd_key;
      in_entry.round  = in_round;
      in_entry.mix    = is_mix_round(in_round);
      in_entry.keyerr = ~rd_ok;
   end

   aes_skid_fifo2 #(
      .W($bits(ark_entry_t))
   ) u_obuf (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_entry),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_entry)
   );

   assign out_state  = out_entry.state;
   assign out_round  = out_entry.round;
   assign out_mix    = out_entry.mix;
   assign out_keyerr = out_entry.keyerr;

endmodule

// File: tb/tb_aes_inv_ark_stage.sv
// Self-checking bench for aes_inv_ark_stage: directed cases with literal
// expectations plus randomized traffic checked against a behavioural model.
module tb_aes_inv_ark_stage;

   localparam int EW = 134;  // {state[128], round[4], mix, keyerr}

   // ---------------- clock / reset / DUT ----------------
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         key_we = 1'b0;
   logic [3:0]   key_idx = '0;
   logic [127:0] key_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_state = '0;
   logic [3:0]   in_round = '0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [127:0] out_state;
   logic [3:0]   out_round;
   logic         out_mix;
   logic         out_keyerr;

   always #5 clk = ~clk;

   aes_inv_ark_stage dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_we     (key_we),
      .key_idx    (key_idx),
      .key_data   (key_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_state   (in_state),
      .in_round   (in_round),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_state  (out_state),
      .out_round  (out_round),
      .out_mix    (out_mix),
      .out_keyerr (out_keyerr)
   );

   // ---------------- reference model / scoreboard ----------------
   int            checks = 0;
   int            errors = 0;
   logic [127:0]  ref_key [0:10];
   bit            ref_loaded [0:10];
   logic [EW-1:0] exp_q[$];
   bit            rand_bp = 1'b0;

   function automatic logic [EW-1:0] model(input logic [127:0] s, input logic [3:0] r);
      bit           err;
      logic [127:0] k;
      bit           mix;
      err = 1'b1;
      if (r <= 4'd10) err = !ref_loaded[r];
      k   = err ? 128'd0 : ref_key[r];
      mix = (r >= 4'd1) && (r <= 4'd9);
      return {s ^ k, r, mix, err};
   endfunction

   task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a pop happens at the next rising edge whenever valid && ready
   // are seen here; compare the head against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", {out_state, out_round, out_mix, out_keyerr}, '0);
            if (out_state == '0 && out_round == '0 && !out_mix && !out_keyerr) begin
               errors++;
               $display("FAIL unexpected_output: got output with empty expected queue");
            end
         end else begin
            check("output", {out_state, out_round, out_mix, out_keyerr}, exp_q.pop_front());
         end
      end
   end

   always @(posedge clk) begin
      if (rand_bp) begin
         #1 out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic load_key(input logic [3:0] idx, input logic [127:0] d);
      key_we = 1'b1; key_idx = idx; key_data = d;
      @(posedge clk);
      if (rst_n && idx <= 4'd10) begin
         ref_key[idx] = d;
         ref_loaded[idx] = 1'b1;
      end
      #1 key_we = 1'b0;
   endtask

   task automatic send(input logic [127:0] s, input logic [3:0] r, input bit use_lit,
                       input logic [EW-1:0] lit, input bit kwe, input logic [3:0] kidx,
                       input logic [127:0] kd, output int stalls);
      in_valid = 1'b1; in_state = s; in_round = r; stalls = 0;
      while (!in_ready && stalls < 50) begin
         @(posedge clk); #1; stalls++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, required 1", stalls);
         in_valid = 1'b0;
         return;
      end
      key_we = kwe; key_idx = kidx; key_data = kd;
      @(posedge clk);
      exp_q.push_back(use_lit ? lit : model(s, r));
      if (kwe && kidx <= 4'd10) begin
         ref_key[kidx] = kd;
         ref_loaded[kidx] = 1'b1;
      end
      #1 in_valid = 1'b0; key_we = 1'b0;
   endtask

   task automatic send_m(input logic [127:0] s, input logic [3:0] r);
      int st;
      send(s, r, 1'b0, '0, 1'b0, 4'd0, '0, st);
   endtask

   task automatic send_l(input logic [127:0] s, input logic [3:0] r, input logic [EW-1:0] lit);
      int st;
      send(s, r, 1'b1, lit, 1'b0, 4'd0, '0, st);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); n++;
      end
      check("drain_left", EW'(exp_q.size()), '0);
      #1;
   endtask

   // ---------------- stimulus ----------------
   localparam logic [127:0] K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] S2   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] A5S  = {16{8'hA5}};
   localparam logic [127:0] KOLD = {16{8'h11}};
   localparam logic [127:0] KNEW = {16{8'h22}};

   initial begin
      int st;
      int stall_sum;
      logic [127:0] rs;
      for (int i = 0; i <= 10; i++) begin
         ref_loaded[i] = 1'b0;
         ref_key[i] = '0;
      end

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", EW'(in_ready), '0);
      check("rst_out", {out_valid, out_state, out_round, out_mix, out_keyerr}, '0);
      rst_n = 1'b1;
      check("rel_in_ready_before_edge", EW'(in_ready), '0);
      @(posedge clk); #1;
      check("rel_in_ready_after_edge", EW'(in_ready), EW'(1));

      // Final-round key, latency of one edge
      out_ready = 1'b1;
      load_key(4'd10, K10);
      send_l('0, 4'd10, {K10, 4'd10, 1'b0, 1'b0});
      check("latency_out_valid", EW'(out_valid), EW'(1));
      drain();

      // Middle round with all-ones key
      load_key(4'd5, '1);
      send_l(S2, 4'd5, {128'hffeeddccbbaa99887766554433221100, 4'd5, 1'b1, 1'b0});
      drain();

      // Unloaded key and out-of-range round
      send_l(A5S, 4'd3, {A5S, 4'd3, 1'b1, 1'b1});
      send_l(A5S, 4'd12, {A5S, 4'd12, 1'b0, 1'b1});
      drain();

      // Backpressure: third push must stall until the consumer drains
      out_ready = 1'b0;
      send_m(128'h9, 4'd9);
      send_m(128'h8, 4'd8);
      in_valid = 1'b1; in_state = 128'h7; in_round = 4'd7;
      check("full_in_ready", EW'(in_ready), '0);
      @(posedge clk); #1;
      check("full_in_ready_hold", EW'(in_ready), '0);
      check("full_head_stable", EW'({out_valid, out_round}), EW'({1'b1, 4'd9}));
      out_ready = 1'b1;
      send_m(128'h7, 4'd7);
      drain();

      // Same-cycle key write is not visible to the accept it coincides with
      load_key(4'd4, KOLD);
      send('0, 4'd4, 1'b1, {KOLD, 4'd4, 1'b1, 1'b0}, 1'b1, 4'd4, KNEW, st);
      send_l('0, 4'd4, {KNEW, 4'd4, 1'b1, 1'b0});
      drain();

      // Reset with two entries buffered; key write during reset is dropped
      out_ready = 1'b0;
      send_m(128'h1234, 4'd2);
      send_m(128'h5678, 4'd3);
      rst_n = 1'b0;
      key_we = 1'b1; key_idx = 4'd6; key_data = KNEW;
      @(posedge clk);
      exp_q.delete();
      for (int i = 0; i <= 10; i++) ref_loaded[i] = 1'b0;
      #1 key_we = 1'b0;
      check("midrst_out", {out_valid, out_state, out_round, out_mix, out_keyerr}, '0);
      check("midrst_in_ready", EW'(in_ready), '0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      send_l(A5S, 4'd1, {A5S, 4'd1, 1'b1, 1'b1});
      send_l(S2, 4'd6, {S2, 4'd6, 1'b1, 1'b1});
      drain();

      // Throughput: back-to-back accepts with the consumer always ready
      for (int i = 0; i <= 10; i++) load_key(4'(i), {$urandom, $urandom, $urandom, $urandom});
      stall_sum = 0;
      for (int i = 0; i < 20; i++) begin
         rs = {$urandom, $urandom, $urandom, $urandom};
         send(rs, 4'($urandom_range(0, 10)), 1'b0, '0, 1'b0, 4'd0, '0, st);
         stall_sum += st;
      end
      check("throughput_stalls", EW'(stall_sum), '0);
      drain();

      // Randomized traffic with random backpressure and key updates
      rst_n = 1'b0;
      @(posedge clk);
      for (int i = 0; i <= 10; i++) ref_loaded[i] = 1'b0;
      #1 rst_n = 1'b1;
      rand_bp = 1'b1;
      for (int i = 0; i < 300; i++) begin
         rs = {$urandom, $urandom, $urandom, $urandom};
         send(rs, 4'($urandom_range(0, 12)), 1'b0, '0, ($urandom_range(0, 2) == 0),
              4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom}, st);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end
      rand_bp = 1'b0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
